// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped UART transmitter, 8N1, LSB first, with a byte FIFO.
//
// A CPU store to the TX data address pushes one byte into the FIFO. The FSM
// pops bytes and serialises them onto tx. Stop bits run straight into the next
// start bit while bytes are queued, so queued frames have no idle gap.
//
// Handshake: wr_en is a push request with no ready signal. fifo_full acts as
// "not ready". A push is accepted only when wr_en=1 and the registered
// fifo_full=0 at the start of the cycle. A push made while full is dropped and
// sets the sticky overflow flag. clr_ovf clears that flag; a drop in the same
// cycle wins over clr_ovf.
//
// Optional feature: define IO_UART_TX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit (11-bit frame). When it is undefined
// the frame is 8N1 and no parity logic is built.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
//   FIFO_AW       FIFO address width; depth = 2**FIFO_AW bytes
//
// Ports:
//   clock       system clock
//   reset       synchronous, active-high reset
//   wr_en       push wr_data into the FIFO
//   wr_data     byte to transmit
//   clr_ovf     clear the overflow flag
//   fifo_full   FIFO holds 2**FIFO_AW bytes
//   fifo_empty  FIFO holds 0 bytes
//   fifo_count  bytes queued, excluding the byte being shifted out
//   busy        FSM not idle, or FIFO not empty
//   overflow    sticky; a push was dropped
//   tx          serial line, idles high, driven from a register
//   fsm_state   debug view of the FSM state register
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_AW      = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  input  logic               clr_ovf,
  output logic               fifo_full,
  output logic               fifo_empty,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               busy,
  output logic               overflow,
  output logic               tx,
  output logic [2:0]         fsm_state
);

  localparam int          DEPTH     = 1 << FIFO_AW;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef IO_UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  // FIFO storage and registered status
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count_q;
  logic               overflow_q;
  logic               push;
  logic               drop;
  logic               pop;

  // Transmit FSM registers and next-state values
  state_t      state_q, state_n;
  logic [15:0] baud_q, baud_n;
  logic [2:0]  bit_q, bit_n;
  logic [7:0]  shift_q, shift_n;
  logic        tx_q, tx_n;
  logic        bit_end;
`ifdef IO_UART_TX_PARITY_EN
  logic        par_q, par_n;
`endif

  // Status comes only from registers, so nothing here depends on wr_en.
  // count_q never exceeds DEPTH, so its MSB is set exactly when full.
  assign fifo_full  = count_q[FIFO_AW];
  assign fifo_empty = (count_q == '0);
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign overflow   = overflow_q;
  assign tx         = tx_q;
  assign fsm_state  = state_q;

  assign push = wr_en && !fifo_full;
  assign drop = wr_en && fifo_full;

  // ---------------------------------------------------------------------------
  // FIFO pointers, count and overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      overflow_q <= drop | (overflow_q & ~clr_ovf);
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef IO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      tx_q    <= tx_n;
`ifdef IO_UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state, pop request and next tx level
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    pop     = 1'b0;
    tx_n    = 1'b1;
    bit_end = (baud_q == BAUD_LAST);
`ifdef IO_UART_TX_PARITY_EN
    par_n   = par_q;
`endif

    // Outside IDLE the baud counter free-runs over one bit period.
    if (state_q != S_IDLE) begin
      baud_n = bit_end ? '0 : baud_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = S_START;
`ifdef IO_UART_TX_PARITY_EN
          par_n   = ^mem[rd_ptr];
`endif
        end
      end

      S_START: begin
        if (bit_end) begin
          bit_n   = '0;
          state_n = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          shift_n = {1'b0, shift_q[7:1]};
          bit_n   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end

`ifdef IO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_n = S_STOP;
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          // A queued byte starts immediately, giving back-to-back frames.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            bit_n   = '0;
            state_n = S_START;
`ifdef IO_UART_TX_PARITY_EN
            par_n   = ^mem[rd_ptr];
`endif
          end else begin
            state_n = S_IDLE;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase

    // tx is registered from the upcoming state, so the line changes on the
    // same edge as the state and never glitches.
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
`ifdef IO_UART_TX_PARITY_EN
      S_PARITY: tx_n = par_n;
`endif
      default:  tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: self-checking bench for io_uart_tx (CLKS_PER_BIT=4, FIFO_AW=3).
// A line monitor decodes frames off tx and compares each decoded byte with the
// head of a scoreboard queue filled when bytes are pushed.
module tb_io_uart_tx;

  localparam int CPB = 4;
  localparam int AW  = 3;
`ifdef IO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic          clock   = 1'b0;
  logic          reset   = 1'b1;
  logic          wr_en   = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          clr_ovf = 1'b0;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          busy;
  logic          overflow;
  logic          tx;
  logic [2:0]    fsm_state;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  io_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW     (AW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_ovf   (clr_ovf),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .fifo_count(fifo_count),
    .busy      (busy),
    .overflow  (overflow),
    .tx        (tx),
    .fsm_state (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line monitor: samples tx one cycle into every bit period
  // ---------------------------------------------------------------------------
  bit         mon_active = 1'b0;
  logic       mon_prev   = 1'b1;
  int         mon_cyc    = 0;
  int         mon_bit    = 0;
  logic [7:0] mon_byte   = 8'h00;
  logic       mon_par    = 1'b0;
  logic [7:0] mon_exp    = 8'h00;
  int         frames_started = 0;
  int         start_cyc      = 0;
  int         prev_start_cyc = 0;

  always @(negedge clock) begin
    if (reset) begin
      mon_active = 1'b0;
      mon_prev   = 1'b1;
    end else if (!mon_active) begin
      if (mon_prev && !tx) begin
        mon_active     = 1'b1;
        mon_cyc        = 0;
        prev_start_cyc = start_cyc;
        start_cyc      = cyc;
        frames_started++;
      end
      mon_prev = tx;
    end else begin
      mon_cyc++;
      if (mon_cyc % CPB == 1) begin
        mon_bit = mon_cyc / CPB;
        if (mon_bit == 0) begin
          check("start_bit", 32'(tx), 32'd0);
        end else if (mon_bit <= 8) begin
          mon_byte[mon_bit-1] = tx;
        end
`ifdef IO_UART_TX_PARITY_EN
        else if (mon_bit == 9) begin
          mon_par = tx;
        end
`endif
        else begin
          check("stop_bit", 32'(tx), 32'd1);
          check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check("rx_byte", 32'(mon_byte), 32'(mon_exp));
`ifdef IO_UART_TX_PARITY_EN
            check("parity_bit", 32'(mon_par), 32'(^mon_exp));
`endif
          end
          mon_active = 1'b0;
          mon_prev   = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at the next negedge)
  // ---------------------------------------------------------------------------
  task automatic push(input logic [7:0] b, input bit accept);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
    @(negedge clock);
    wr_en   = 1'b0;
  endtask

  task automatic wait_start(input int target, input int budget);
    int n = 0;
    while (frames_started < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("frame_start_timeout", 32'(frames_started >= target), 32'd1);
  endtask

  task automatic wait_cyc(input int t);
    int n = 0;
    while (cyc < t && n < 1000) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic wait_idle(input int budget, output int t);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    t = cyc;
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: one isolated frame per entry
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    int         exp_latency;   // wr_en cycle to tx falling
    int         exp_busy_len;  // tx falling to busy low
  } vec_t;

  vec_t vecs[7];

  initial begin
    int push_cyc;
    int idle_cyc;
    int base;

    vecs[0] = '{8'h55, 2, FRAME};
    vecs[1] = '{8'h00, 2, FRAME};
    vecs[2] = '{8'hFF, 2, FRAME};
    vecs[3] = '{8'h80, 2, FRAME};
    vecs[4] = '{8'h01, 2, FRAME};
    vecs[5] = '{8'h07, 2, FRAME};
    vecs[6] = '{8'h03, 2, FRAME};

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_tx",       32'(tx),         32'd1);
    check("rst_empty",    32'(fifo_empty), 32'd1);
    check("rst_full",     32'(fifo_full),  32'd0);
    check("rst_count",    32'(fifo_count), 32'd0);
    check("rst_busy",     32'(busy),       32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single frames: latency, frame length, decoded data
    for (int i = 0; i < 7; i++) begin
      base     = frames_started;
      push_cyc = cyc;
      push(vecs[i].data, 1'b1);
      wait_start(base + 1, 20);
      check("tx_latency", 32'(start_cyc - push_cyc), 32'(vecs[i].exp_latency));
      wait_idle(FRAME + 20, idle_cyc);
      check("busy_len", 32'(idle_cyc - start_cyc), 32'(vecs[i].exp_busy_len));
      check("idle_tx", 32'(tx), 32'd1);
      repeat (3) @(negedge clock);
    end

    // Back-to-back frames
    base = frames_started;
    push(8'hA3, 1'b1);
    push(8'h0F, 1'b1);
    wait_start(base + 1, 20);
    wait_cyc(start_cyc + 10);
    check("b2b_count", 32'(fifo_count), 32'd1);
    wait_start(base + 2, FRAME + 20);
    check("b2b_gap", 32'(start_cyc - prev_start_cyc), 32'(FRAME));
    wait_idle(FRAME + 20, idle_cyc);
    repeat (3) @(negedge clock);

    // Fill to full, overflow, clear
    for (int i = 0; i < 9; i++) begin
      push(8'(i), 1'b1);
      if (i == 7) begin
        check("fill7_count", 32'(fifo_count), 32'd7);
        check("fill7_full",  32'(fifo_full),  32'd0);
      end
    end
    check("full_count",    32'(fifo_count), 32'd8);
    check("full_flag",     32'(fifo_full),  32'd1);
    check("full_no_ovf",   32'(overflow),   32'd0);
    push(8'hFF, 1'b0);
    check("ovf_set",       32'(overflow),   32'd1);
    check("ovf_count",     32'(fifo_count), 32'd8);
    clr_ovf = 1'b1;
    push(8'hFF, 1'b0);
    clr_ovf = 1'b0;
    check("ovf_set_wins",  32'(overflow),   32'd1);
    clr_ovf = 1'b1;
    @(negedge clock);
    clr_ovf = 1'b0;
    check("ovf_cleared",   32'(overflow),   32'd0);
    check("ovf_count2",    32'(fifo_count), 32'd8);
    wait_idle(9 * FRAME + 100, idle_cyc);
    repeat (3) @(negedge clock);

    // Reset during data bit 3
    base = frames_started;
    push(8'hC8, 1'b1);
    wait_start(base + 1, 20);
    wait_cyc(start_cyc + 18);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_tx",    32'(tx),         32'd1);
    check("midrst_empty", 32'(fifo_empty), 32'd1);
    check("midrst_busy",  32'(busy),       32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    base = frames_started;
    push(8'h01, 1'b1);
    wait_start(base + 1, 20);
    wait_idle(FRAME + 20, idle_cyc);
    repeat (3) @(negedge clock);

    // Push in the same cycle as a stop-to-start pop at count 3
    base = frames_started;
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 1'b1);
    check("pp_pre_count", 32'(fifo_count), 32'd3);
    wait_start(base + 1, 20);
    wait_cyc(start_cyc + FRAME - 1);
    push(8'h14, 1'b1);
    check("pp_count", 32'(fifo_count), 32'd3);
    wait_start(base + 2, 20);
    check("pp_gap", 32'(start_cyc - prev_start_cyc), 32'(FRAME));
    wait_idle(5 * FRAME + 100, idle_cyc);
    repeat (3) @(negedge clock);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Memory-mapped UART transmitter peripheral, 8N1, LSB first. It is the transmit-direction counterpart of the UART programming receiver.
- Instantiated under MEM_IO. The CPU's store to the TX data address drives wr_en/wr_data. Status bits are returned on the IO read path.
- Contains a small byte FIFO, so software can queue several characters without polling per bit.
- Runs in the CPU clock domain; the baud rate is derived by an integer divider.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200). Legal range 2..65535.
- FIFO_AW, 3, FIFO address width. Depth = 2**FIFO_AW = 8 bytes.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  push wr_data into the FIFO (one byte per cycle).
- wr_data  input  8  byte to transmit.
- clr_ovf  input  1  clears the overflow flag.
- fifo_full  output  1  FIFO holds 2**FIFO_AW bytes.
- fifo_empty  output  1  FIFO holds 0 bytes.
- fifo_count  output  FIFO_AW+1  number of bytes queued; excludes the byte currently being shifted out.
- busy  output  1  high when state != IDLE or FIFO is not empty.
- overflow  output  1  sticky; set when a push is dropped.
- tx  output  1  serial line; idles high.

Behaviour:
- Reset (synchronous, active-high): tx=1, state=IDLE, FIFO pointers=0, fifo_count=0, fifo_empty=1, fifo_full=0, busy=0, overflow=0, baud counter=0, bit index=0.
- FIFO: circular buffer with registered read and write pointers; pointers wrap modulo depth.
  - A push is accepted when wr_en=1 and fifo_full=0, judged on registered status at the start of the cycle.
  - wr_en=1 while full: the byte is dropped, FIFO is unchanged, overflow=1 at the next edge.
  - A push and a pop in the same cycle: both occur and fifo_count is unchanged.
  - clr_ovf=1 clears overflow at the next edge. If clr_ovf and a dropped push occur in the same cycle, set wins.
- Baud counter counts 0..CLKS_PER_BIT-1. Each bit period ends when the counter reaches CLKS_PER_BIT-1; the counter then returns to 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is non-empty, pop the head into the shift register, reset the baud counter and go to START, all at the same edge.
  - START: tx=0 for one bit period, then go to DATA with bit index=0.
  - DATA: tx=shift[0]. At the end of each bit period, shift right and increment the bit index. After bit 7 ends, go to STOP.
  - STOP: tx=1 for one bit period. At its end:
    - FIFO non-empty: pop and go directly to START, giving back-to-back frames with no idle gap.
    - FIFO empty: go to IDLE.
- tx is driven from a register (glitch-free).
- Frame length: exactly 10*CLKS_PER_BIT cycles; 11*CLKS_PER_BIT with parity enabled.
- Latency, write into an empty FIFO while IDLE:
  - wr_en asserted in cycle N: the byte is stored at edge N+1.
  - The pop occurs at edge N+2; tx falls after edge N+2.
- reset asserted mid-frame: tx returns to 1 at the next edge and all queued bytes are discarded.
- fifo_count, fifo_full, fifo_empty, busy and overflow are all registered or derived only from registers; no combinational path from wr_en.

Optional Feature:
- Macro IO_UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP. tx = XOR of the 8 data bits (even parity) for one bit period. Frame becomes 11 bit periods.
- Undefined: no PARITY state, 8N1 framing, and no parity logic is synthesized.

Test Plan (CLKS_PER_BIT=4, FIFO_AW=3 unless noted):
1. Reset, then push 0x55 once -> tx falls 2 cycles after wr_en. The line then carries, 4 cycles per bit: 0 (start), 1,0,1,0,1,0,1,0 (data, LSB first), 1 (stop). busy returns to 0 exactly 40 cycles after tx falls.
2. Push 0xA3, 0x0F on consecutive cycles -> two frames with no idle gap; the second start bit begins 40 cycles after the first. Decoded bytes are 0xA3 then 0x0F; fifo_count reads 1 during the first frame.
3. Push 9 bytes 0x00..0x08 on consecutive cycles while idle -> first byte is popped, so 8 are queued. Check fifo_full is 1 exactly when 8 are queued and overflow is 0. Then push 0xFF while full -> overflow=1 and fifo_count stays 8. Pulse clr_ovf -> overflow=0. Transmitted sequence is 0x00..0x08; 0xFF is absent.
4. Start a frame with 0xC8, assert reset during data bit 3 -> tx=1 the next cycle, fifo_empty=1, busy=0. A new push of 0x01 afterwards transmits correctly.
5. With the FIFO at count 3 mid-frame, assert wr_en in the same cycle the FSM pops -> fifo_count stays 3 and no byte is lost or duplicated.
6. IO_UART_TX_PARITY_EN defined, push 0x07 -> parity bit 1 after bit 7 and frame length 44 cycles. Push 0x03 -> parity bit 0.
